// File: rtl/lock_sequencer_if.sv
// lock_sequencer_if: key pulses, switch word and status/display outputs of the lock sequencer
interface lock_sequencer_if #(parameter int PW_W = 4);
    logic            chk_p;
    logic            clr_p;
    logic            set_p;
    logic [PW_W-1:0] pwswt;
    logic            unlocked;
    logic            set_mode;
    logic            lockout;
    logic [3:0]      chances;
    logic            bad_pw;
    logic [3:0]      digit_tens;
    logic [3:0]      digit_ones;
    modport master (
        output chk_p, clr_p, set_p, pwswt,
        input  unlocked, set_mode, lockout, chances, bad_pw, digit_tens, digit_ones
    );
    modport slave (
        input  chk_p, clr_p, set_p, pwswt,
        output unlocked, set_mode, lockout, chances, bad_pw, digit_tens, digit_ones
    );
endinterface

// File: rtl/lock_sequencer.sv
// lock_sequencer: password lock FSM with retry budget, timed lockout, auto-relock and password change
module lock_sequencer #(
    parameter int PW_W      = 4,
    parameter int MAX_TRIES = 5,
    parameter int TICK_DIV  = 50_000_000,
    parameter int LOCKOUT_S = 30,
    parameter int RELOCK_S  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    lock_sequencer_if.slave  bus
);
    localparam logic [1:0] S_LOCKED  = 2'd0;
    localparam logic [1:0] S_OPEN    = 2'd1;
    localparam logic [1:0] S_SETPW   = 2'd2;
    localparam logic [1:0] S_LOCKOUT = 2'd3;
    localparam int PS_W = $clog2(TICK_DIV);
    localparam logic [PS_W-1:0] PS_MAX   = PS_W'(TICK_DIV - 1);
    localparam logic [3:0]      TRIES    = 4'(MAX_TRIES);
    localparam logic [6:0]      LOCK_T   = 7'(LOCKOUT_S);
    localparam logic [6:0]      RELOCK_T = 7'(RELOCK_S);
    localparam logic [3:0]      RST_TENS = 4'(MAX_TRIES / 10);
    localparam logic [3:0]      RST_ONES = 4'(MAX_TRIES % 10);

    logic [1:0]      state_q, state_d;
    logic [PW_W-1:0] pw_q, pw_d;
    logic [3:0]      chances_q, chances_d;
    logic [6:0]      timer_q, timer_d;
    logic [PS_W-1:0] presc_q, presc_d;
    logic            bad_q, bad_d;
    logic [3:0]      tens_q, tens_d;
    logic [3:0]      ones_q, ones_d;
    logic            clr, set, chk, tick, expire;
    logic [6:0]      val;

    // next-state logic: key priority clr > set > chk, keys win over a same-cycle timer expiry
    always_comb begin
        clr       = bus.clr_p;
        set       = bus.set_p & ~bus.clr_p;
        chk       = bus.chk_p & ~bus.clr_p & ~bus.set_p;
        tick      = presc_q == PS_MAX;
        expire    = tick && timer_q == 7'd1;
        state_d   = state_q;
        pw_d      = pw_q;
        chances_d = chances_q;
        timer_d   = (tick && timer_q != 7'd0) ? timer_q - 7'd1 : timer_q;
        bad_d     = 1'b0;
        case (state_q)
            S_LOCKED: begin
                if (clr) begin
                    chances_d = TRIES;
                end else if (chk && bus.pwswt == pw_q) begin
                    state_d   = S_OPEN;
                    chances_d = TRIES;
                    timer_d   = RELOCK_T;
                end else if (chk) begin
                    bad_d     = 1'b1;
                    state_d   = chances_q <= 4'd1 ? S_LOCKOUT : S_LOCKED;
                    chances_d = chances_q <= 4'd1 ? 4'd0 : chances_q - 4'd1;
                    timer_d   = chances_q <= 4'd1 ? LOCK_T : 7'd0;
                end
            end
            S_OPEN: begin
                if (set) begin
                    state_d = S_SETPW;
                    timer_d = RELOCK_T;
                end else if (clr || chk || expire) begin
                    state_d = S_LOCKED;
                    timer_d = 7'd0;
                end
            end
            S_SETPW: begin
                if (chk || clr) begin
                    pw_d    = chk ? bus.pwswt : pw_q;
                    state_d = S_OPEN;
                    timer_d = RELOCK_T;
                end else if (expire) begin
                    state_d = S_LOCKED;
                    timer_d = 7'd0;
                end
            end
            default: begin
                if (expire) begin
                    state_d   = S_LOCKED;
                    chances_d = TRIES;
                    timer_d   = 7'd0;
                end
            end
        endcase
        presc_d = (state_d != state_q || tick) ? '0 : presc_q + PS_W'(1);
        val     = state_d == S_LOCKOUT ? timer_d : {3'd0, chances_d};
        tens_d  = 4'(val / 7'd10);
        ones_d  = 4'(val % 7'd10);
    end

    // state, counters and display digits, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_LOCKED;
            pw_q      <= '0;
            chances_q <= TRIES;
            timer_q   <= '0;
            presc_q   <= '0;
            bad_q     <= 1'b0;
            tens_q    <= RST_TENS;
            ones_q    <= RST_ONES;
        end else begin
            state_q   <= state_d;
            pw_q      <= pw_d;
            chances_q <= chances_d;
            timer_q   <= timer_d;
            presc_q   <= presc_d;
            bad_q     <= bad_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
        end
    end

    assign bus.unlocked   = state_q == S_OPEN || state_q == S_SETPW;
    assign bus.set_mode   = state_q == S_SETPW;
    assign bus.lockout    = state_q == S_LOCKOUT;
    assign bus.chances    = chances_q;
    assign bus.bad_pw     = bad_q;
    assign bus.digit_tens = tens_q;
    assign bus.digit_ones = ones_q;
endmodule

// File: tb/tb_lock_sequencer.sv
// tb_lock_sequencer: directed vector table plus hand-written timing and reset sequences
module tb_lock_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lock_sequencer_if #(.PW_W(4)) bus ();

    lock_sequencer #(
        .PW_W(4), .MAX_TRIES(3), .TICK_DIV(4), .LOCKOUT_S(5), .RELOCK_S(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        logic        chk, clr, set;
        logic [3:0]  pw;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[17];

    function automatic logic [15:0] ex(logic u, logic s, logic l, logic [3:0] ch,
                                       logic b, logic [3:0] t, logic [3:0] o);
        return {u, s, l, ch, b, t, o};
    endfunction

    function automatic vec_t mk(logic c, logic l, logic s, logic [3:0] pw, logic [15:0] e);
        vec_t v;
        v.chk = c; v.clr = l; v.set = s; v.pw = pw; v.exp = e;
        return v;
    endfunction

    function automatic logic [15:0] outs();
        return {bus.unlocked, bus.set_mode, bus.lockout, bus.chances,
                bus.bad_pw, bus.digit_tens, bus.digit_ones};
    endfunction

    task automatic check(string name, logic [15:0] exp);
        logic [15:0] got;
        got = outs();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got u/s/l/ch/bad/tens/ones=%b/%b/%b/%0d/%b/%0d/%0d expected %b/%b/%b/%0d/%b/%0d/%0d",
                     name, got[15], got[14], got[13], got[12:9], got[8], got[7:4], got[3:0],
                     exp[15], exp[14], exp[13], exp[12:9], exp[8], exp[7:4], exp[3:0]);
        end
    endtask

    task automatic step(logic c, logic l, logic s, logic [3:0] pw);
        bus.chk_p = c;
        bus.clr_p = l;
        bus.set_p = s;
        bus.pwswt = pw;
        @(negedge clk);
        bus.chk_p = 1'b0;
        bus.clr_p = 1'b0;
        bus.set_p = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk(1, 0, 0, 4'h0, ex(1, 0, 0, 3, 0, 0, 3));
        vecs[1]  = mk(0, 0, 1, 4'h0, ex(1, 1, 0, 3, 0, 0, 3));
        vecs[2]  = mk(1, 0, 0, 4'hA, ex(1, 0, 0, 3, 0, 0, 3));
        vecs[3]  = mk(0, 1, 0, 4'h0, ex(0, 0, 0, 3, 0, 0, 3));
        vecs[4]  = mk(1, 0, 0, 4'h0, ex(0, 0, 0, 2, 1, 0, 2));
        vecs[5]  = mk(0, 0, 0, 4'h0, ex(0, 0, 0, 2, 0, 0, 2));
        vecs[6]  = mk(1, 0, 0, 4'hA, ex(1, 0, 0, 3, 0, 0, 3));
        vecs[7]  = mk(1, 0, 0, 4'hA, ex(0, 0, 0, 3, 0, 0, 3));
        vecs[8]  = mk(1, 0, 0, 4'h1, ex(0, 0, 0, 2, 1, 0, 2));
        vecs[9]  = mk(0, 1, 0, 4'h1, ex(0, 0, 0, 3, 0, 0, 3));
        vecs[10] = mk(1, 0, 0, 4'h1, ex(0, 0, 0, 2, 1, 0, 2));
        vecs[11] = mk(1, 0, 0, 4'h1, ex(0, 0, 0, 1, 1, 0, 1));
        vecs[12] = mk(1, 1, 0, 4'h1, ex(0, 0, 0, 3, 0, 0, 3));
        vecs[13] = mk(1, 0, 1, 4'hA, ex(0, 0, 0, 3, 0, 0, 3));
        vecs[14] = mk(1, 0, 0, 4'h1, ex(0, 0, 0, 2, 1, 0, 2));
        vecs[15] = mk(1, 0, 0, 4'h1, ex(0, 0, 0, 1, 1, 0, 1));
        vecs[16] = mk(1, 0, 0, 4'h1, ex(0, 0, 1, 0, 1, 0, 5));
        bus.chk_p = 1'b0;
        bus.clr_p = 1'b0;
        bus.set_p = 1'b0;
        bus.pwswt = 4'h0;
        @(negedge clk);
        @(negedge clk);
        check("reset", ex(0, 0, 0, 3, 0, 0, 3));
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            step(vecs[i].chk, vecs[i].clr, vecs[i].set, vecs[i].pw);
            check($sformatf("row%0d", i), vecs[i].exp);
        end
        step(0, 1, 0, 4'hA);
        check("lockout_clr", ex(0, 0, 1, 0, 0, 0, 5));
        step(1, 0, 0, 4'hA);
        check("lockout_chk", ex(0, 0, 1, 0, 0, 0, 5));
        step(0, 0, 1, 4'hA);
        check("lockout_set", ex(0, 0, 1, 0, 0, 0, 5));
        for (int k = 4; k < 20; k++) begin
            step(0, 0, 0, 4'h0);
            check($sformatf("lockout_t%0d", k), ex(0, 0, 1, 0, 0, 0, 4'(5 - k / 4)));
        end
        step(0, 0, 0, 4'h0);
        check("lockout_end", ex(0, 0, 0, 3, 0, 0, 3));
        step(1, 0, 0, 4'hA);
        check("open_entry", ex(1, 0, 0, 3, 0, 0, 3));
        for (int k = 1; k <= 12; k++) begin
            step(0, 0, 0, 4'h0);
            check($sformatf("relock_t%0d", k), ex(k < 12, 0, 0, 3, 0, 0, 3));
        end
        step(1, 0, 0, 4'hA);
        step(0, 0, 1, 4'h0);
        check("setpw_entry", ex(1, 1, 0, 3, 0, 0, 3));
        for (int k = 1; k <= 12; k++) begin
            step(0, 0, 0, 4'h0);
            check($sformatf("setpw_t%0d", k), ex(k < 12, k < 12, 0, 3, 0, 0, 3));
        end
        step(1, 0, 0, 4'hA);
        check("pw_kept", ex(1, 0, 0, 3, 0, 0, 3));
        step(0, 0, 1, 4'h0);
        check("setpw_again", ex(1, 1, 0, 3, 0, 0, 3));
        bus.pwswt = 4'h5;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_rst", ex(0, 0, 0, 3, 0, 0, 3));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        step(1, 0, 0, 4'h5);
        check("post_rst_pw5", ex(0, 0, 0, 2, 1, 0, 2));
        step(1, 0, 0, 4'h0);
        check("post_rst_pw0", ex(1, 0, 0, 3, 0, 0, 3));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
